// File: rtl/vga_pkg.sv
// Shared VGA timing, colour and frame-buffer constants plus the RGB444 payload type.
package vga_pkg;

  localparam int unsigned c_h_visible  = 640;
  localparam int unsigned c_h_fporch   = 16;
  localparam int unsigned c_h_sync     = 96;
  localparam int unsigned c_h_bporch   = 48;
  localparam int unsigned c_v_visible  = 480;
  localparam int unsigned c_v_fporch   = 10;
  localparam int unsigned c_v_sync     = 2;
  localparam int unsigned c_v_bporch   = 33;

  localparam int unsigned c_nb_color   = 4;
  localparam int unsigned c_nb_rgb     = 3 * c_nb_color;
  localparam int unsigned c_nb_coord   = 10;
  localparam int unsigned c_img_w      = 160;
  localparam int unsigned c_img_h      = 120;
  localparam int unsigned c_up_log2    = 2;
  localparam int unsigned c_fb_nb_addr = 16;
  localparam logic        c_sync_active = 1'b0;

  typedef struct packed {
    logic [c_nb_color-1:0] red;
    logic [c_nb_color-1:0] green;
    logic [c_nb_color-1:0] blue;
  } rgb444_t;

  typedef enum logic {st_idle, st_pending} swap_state_t;

  // Frame-buffer words are packed {R,G,B}, matching the struct field order.
  function automatic rgb444_t to_rgb(input logic [c_nb_rgb-1:0] w);
    return rgb444_t'(w);
  endfunction

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Pipeline stage 1: scaled frame-buffer read address and image-area flag.
module vga_fb_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned c_img_cols     = c_img_w,
  parameter int unsigned c_img_rows     = c_img_h,
  parameter int unsigned c_scale_log2   = c_up_log2,
  parameter int unsigned c_nb_addr      = c_fb_nb_addr,
  parameter int unsigned c_pxl_visible  = c_h_visible,
  parameter int unsigned c_line_visible = c_v_visible
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fb_sel,
  input  logic [c_nb_coord-1:0] col,
  input  logic [c_nb_coord-1:0] row,
  output logic [c_nb_addr-1:0]  fb_addr,
  output logic                  in_img
);

  localparam int unsigned c_frame_words = c_img_cols * c_img_rows;
  localparam int unsigned c_cols_scr    = c_img_cols << c_scale_log2;
  localparam int unsigned c_rows_scr    = c_img_rows << c_scale_log2;
  // Image area clipped to the visible screen in case the upscaled image overhangs it.
  localparam int unsigned c_cols_lim    = (c_cols_scr < c_pxl_visible)  ? c_cols_scr : c_pxl_visible;
  localparam int unsigned c_rows_lim    = (c_rows_scr < c_line_visible) ? c_rows_scr : c_line_visible;

  logic [31:0] addr_c;
  logic        in_img_c;

  always_comb begin
    addr_c   = (fb_sel ? c_frame_words : 32'd0)
             + 32'(row >> c_scale_log2) * c_img_cols
             + 32'(col >> c_scale_log2);
    in_img_c = (32'(col) < c_cols_lim) && (32'(row) < c_rows_lim);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fb_addr <= '0;
      in_img  <= 1'b0;
    end else begin
      fb_addr <= c_nb_addr'(addr_c);
      in_img  <= in_img_c;
    end
  end

endmodule

// File: rtl/vga_fb_display.sv
// Frame-buffer to VGA pixel pipeline with upscaling, test bars and
// vertical-blank-synchronised double-buffer swap arbitration.
module vga_fb_display
  import vga_pkg::*;
#(
  parameter int unsigned         c_img_cols     = c_img_w,
  parameter int unsigned         c_img_rows     = c_img_h,
  parameter int unsigned         c_scale_log2   = c_up_log2,
  parameter int unsigned         c_nb_addr      = c_fb_nb_addr,
  parameter int unsigned         c_nb_pxl       = c_nb_rgb,
  parameter int unsigned         c_pxl_visible  = c_h_visible,
  parameter int unsigned         c_line_visible = c_v_visible,
  parameter logic [c_nb_pxl-1:0] c_border       = '0,
  parameter logic                c_synch_act    = c_sync_active
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  visible,
  input  logic                  new_pxl,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [c_nb_coord-1:0] col,
  input  logic [c_nb_coord-1:0] row,
  input  logic                  test_mode,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  fb_sel,
  output logic [c_nb_addr-1:0]  fb_addr,
  input  logic [c_nb_pxl-1:0]   fb_data,
  output logic [c_nb_color-1:0] vga_red,
  output logic [c_nb_color-1:0] vga_green,
  output logic [c_nb_color-1:0] vga_blue,
  output logic                  vga_hsync,
  output logic                  vga_vsync
);

  swap_state_t state;
  logic        s1_visible, s1_hsync, s1_vsync, s1_in_img;
  logic [2:0]  s1_bars;
  logic        s2_visible, s2_hsync, s2_vsync, s2_in_img;
  logic [2:0]  s2_bars;
  rgb444_t     pix_c;
  logic        swap_point_c;

  vga_fb_addr_gen #(
    .c_img_cols     (c_img_cols),
    .c_img_rows     (c_img_rows),
    .c_scale_log2   (c_scale_log2),
    .c_nb_addr      (c_nb_addr),
    .c_pxl_visible  (c_pxl_visible),
    .c_line_visible (c_line_visible)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .fb_sel  (fb_sel),
    .col     (col),
    .row     (row),
    .fb_addr (fb_addr),
    .in_img  (s1_in_img)
  );

  // Flags and syncs ride alongside the address/RAM latency; syncs reset inactive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_visible <= 1'b0;
      s1_hsync   <= ~c_synch_act;
      s1_vsync   <= ~c_synch_act;
      s1_bars    <= '0;
      s2_visible <= 1'b0;
      s2_hsync   <= ~c_synch_act;
      s2_vsync   <= ~c_synch_act;
      s2_in_img  <= 1'b0;
      s2_bars    <= '0;
    end else begin
      s1_visible <= visible;
      s1_hsync   <= hsync_in;
      s1_vsync   <= vsync_in;
      s1_bars    <= col[8:6];
      s2_visible <= s1_visible;
      s2_hsync   <= s1_hsync;
      s2_vsync   <= s1_vsync;
      s2_in_img  <= s1_in_img;
      s2_bars    <= s1_bars;
    end
  end

  always_comb begin
    pix_c = '0;
    if (s2_visible) begin
      if (test_mode) begin
        pix_c.red   = {c_nb_color{s2_bars[2]}};
        pix_c.green = {c_nb_color{s2_bars[1]}};
        pix_c.blue  = {c_nb_color{s2_bars[0]}};
      end else if (!s2_in_img) begin
        pix_c = to_rgb(c_border);
      end else begin
        pix_c = to_rgb(fb_data);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
      vga_hsync <= ~c_synch_act;
      vga_vsync <= ~c_synch_act;
    end else begin
      vga_red   <= pix_c.red;
      vga_green <= pix_c.green;
      vga_blue  <= pix_c.blue;
      vga_hsync <= s2_hsync;
      vga_vsync <= s2_vsync;
    end
  end

  // First pixel strobe of the first blanking line: safe moment to flip buffers.
  assign swap_point_c = new_pxl && (row == c_nb_coord'(c_line_visible)) && (col == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= st_idle;
      fb_sel   <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (swap_point_c && (state == st_pending || swap_req)) begin
        fb_sel   <= ~fb_sel;
        swap_ack <= 1'b1;
        state    <= st_idle;
      end else if (swap_req) begin
        state    <= st_pending;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_display.sv
// Directed, table-driven bench for vga_fb_display with a 1-clk-latency RAM model.
module tb_vga_fb_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, visible, new_pxl, hsync_in, vsync_in, test_mode, swap_req;
  logic [9:0] col, row;

  logic        swap_ack, fb_sel, vga_hsync, vga_vsync;
  logic [15:0] fb_addr;
  logic [11:0] fb_data;
  logic [3:0]  vga_red, vga_green, vga_blue;

  logic        s1_swap_ack, s1_fb_sel, s1_vga_hsync, s1_vga_vsync;
  logic [15:0] s1_fb_addr;
  logic [11:0] s1_fb_data;
  logic [3:0]  s1_vga_red, s1_vga_green, s1_vga_blue;

  int n_checks = 0;
  int n_fail   = 0;

  vga_fb_display dut (
    .clk(clk), .rst(rst), .visible(visible), .new_pxl(new_pxl),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .col(col), .row(row),
    .test_mode(test_mode), .swap_req(swap_req), .swap_ack(swap_ack),
    .fb_sel(fb_sel), .fb_addr(fb_addr), .fb_data(fb_data),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  vga_fb_display #(.c_scale_log2(1), .c_border(12'h3C7)) dut_s1 (
    .clk(clk), .rst(rst), .visible(visible), .new_pxl(new_pxl),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .col(col), .row(row),
    .test_mode(test_mode), .swap_req(swap_req), .swap_ack(s1_swap_ack),
    .fb_sel(s1_fb_sel), .fb_addr(s1_fb_addr), .fb_data(s1_fb_data),
    .vga_red(s1_vga_red), .vga_green(s1_vga_green), .vga_blue(s1_vga_blue),
    .vga_hsync(s1_vga_hsync), .vga_vsync(s1_vga_vsync)
  );

  // RAM contents: address 0 holds A5C, every other word holds its low 12 address bits.
  function automatic logic [11:0] ram_word(input logic [15:0] a);
    return (a == 16'd0) ? 12'hA5C : a[11:0];
  endfunction

  always @(posedge clk) begin
    fb_data    <= ram_word(fb_addr);
    s1_fb_data <= ram_word(s1_fb_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] c, input logic [9:0] r,
                       input logic hs, input logic vs, input logic tm);
    visible   = v;
    col       = c;
    row       = r;
    hsync_in  = hs;
    vsync_in  = vs;
    test_mode = tm;
  endtask

  task automatic swap_point(input logic req);
    row      = 10'd480;
    col      = 10'd0;
    new_pxl  = 1'b1;
    swap_req = req;
    tick();
    new_pxl  = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic pulse_req(input logic [9:0] r);
    row      = r;
    col      = 10'd0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  typedef struct packed {
    logic        vis;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        hs;
    logic        vs;
    logic        tm;
    logic [15:0] addr;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b0, 16'd0,     12'hA5C};
    vecs[1]  = '{1'b1, 10'd4,   10'd0,   1'b1, 1'b1, 1'b0, 16'd1,     12'h001};
    vecs[2]  = '{1'b1, 10'd639, 10'd479, 1'b1, 1'b1, 1'b0, 16'd19199, 12'hAFF};
    vecs[3]  = '{1'b1, 10'd100, 10'd50,  1'b1, 1'b1, 1'b0, 16'd1945,  12'h799};
    vecs[4]  = '{1'b0, 10'd100, 10'd50,  1'b1, 1'b1, 1'b0, 16'd1945,  12'h000};
    vecs[5]  = '{1'b1, 10'd448, 10'd10,  1'b1, 1'b1, 1'b1, 16'd432,   12'hFFF};
    vecs[6]  = '{1'b1, 10'd64,  10'd10,  1'b1, 1'b1, 1'b1, 16'd336,   12'h00F};
    vecs[7]  = '{1'b1, 10'd384, 10'd0,   1'b1, 1'b1, 1'b1, 16'd96,    12'hFF0};
    vecs[8]  = '{1'b0, 10'd656, 10'd0,   1'b0, 1'b1, 1'b0, 16'd164,   12'h000};
    vecs[9]  = '{1'b0, 10'd0,   10'd490, 1'b1, 1'b0, 1'b0, 16'd19520, 12'h000};
    vecs[10] = '{1'b0, 10'd300, 10'd470, 1'b0, 1'b0, 1'b1, 16'd18795, 12'h000};

    rst = 1'b0;
    new_pxl = 1'b0;
    swap_req = 1'b0;
    drive(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);

    // Reset values
    repeat (3) tick();
    check("reset_rgb",   32'({vga_red, vga_green, vga_blue}), 32'h000);
    check("reset_hsync", 32'(vga_hsync), 32'd1);
    check("reset_vsync", 32'(vga_vsync), 32'd1);
    check("reset_fbsel", 32'(fb_sel), 32'd0);
    check("reset_ack",   32'(swap_ack), 32'd0);
    check("reset_addr",  32'(fb_addr), 32'd0);
    rst = 1'b1;
    tick();

    // Table: addressing, RGB select, sync passthrough
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].vis, vecs[i].col, vecs[i].row, vecs[i].hs, vecs[i].vs, vecs[i].tm);
      repeat (3) tick();
      check($sformatf("vec%0d_addr", i),  32'(fb_addr), 32'(vecs[i].addr));
      check($sformatf("vec%0d_rgb", i),   32'({vga_red, vga_green, vga_blue}), 32'(vecs[i].rgb));
      check($sformatf("vec%0d_hsync", i), 32'(vga_hsync), 32'(vecs[i].hs));
      check($sformatf("vec%0d_vsync", i), 32'(vga_vsync), 32'(vecs[i].vs));
    end

    // Scale-by-2 instance: border, in-image, blanking
    drive(1'b1, 10'd320, 10'd10, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check("s1_border_rgb",  32'({s1_vga_red, s1_vga_green, s1_vga_blue}), 32'h3C7);
    check("s1_border_addr", 32'(s1_fb_addr), 32'd960);
    drive(1'b1, 10'd319, 10'd10, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check("s1_img_rgb", 32'({s1_vga_red, s1_vga_green, s1_vga_blue}), 32'h3BF);
    drive(1'b0, 10'd319, 10'd10, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check("s1_blank_rgb", 32'({s1_vga_red, s1_vga_green, s1_vga_blue}), 32'h000);
    drive(1'b1, 10'd0, 10'd240, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check("s1_row_border_rgb", 32'({s1_vga_red, s1_vga_green, s1_vga_blue}), 32'h3C7);

    // Exact 2-clk latency of colour and hsync edge
    drive(1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    drive(1'b1, 10'd4, 10'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check("lat_rgb_early",   32'({vga_red, vga_green, vga_blue}), 32'hA5C);
    check("lat_hsync_early", 32'(vga_hsync), 32'd1);
    tick();
    check("lat_rgb",   32'({vga_red, vga_green, vga_blue}), 32'h001);
    check("lat_hsync", 32'(vga_hsync), 32'd0);

    // Request mid-frame waits for the swap point
    drive(1'b0, 10'd0, 10'd100, 1'b1, 1'b1, 1'b0);
    pulse_req(10'd100);
    check("swp1_hold_sel", 32'(fb_sel), 32'd0);
    check("swp1_hold_ack", 32'(swap_ack), 32'd0);
    row = 10'd480;
    repeat (3) tick();
    check("swp1_nostrobe_sel", 32'(fb_sel), 32'd0);
    swap_point(1'b0);
    check("swp1_sel", 32'(fb_sel), 32'd1);
    check("swp1_ack", 32'(swap_ack), 32'd1);
    tick();
    check("swp1_ack_end", 32'(swap_ack), 32'd0);
    check("swp1_sel_keep", 32'(fb_sel), 32'd1);

    // Two requests coalesce; strobe at col!=0 is not a swap point
    pulse_req(10'd100);
    pulse_req(10'd200);
    row = 10'd480; col = 10'd4; new_pxl = 1'b1;
    tick();
    new_pxl = 1'b0;
    check("swp2_col4_sel", 32'(fb_sel), 32'd1);
    swap_point(1'b0);
    check("swp2_sel", 32'(fb_sel), 32'd0);
    check("swp2_ack", 32'(swap_ack), 32'd1);
    tick();
    check("swp2_ack_end", 32'(swap_ack), 32'd0);
    swap_point(1'b0);
    check("swp2_noreq_sel", 32'(fb_sel), 32'd0);
    check("swp2_noreq_ack", 32'(swap_ack), 32'd0);

    // Request arriving in the swap-point clock swaps immediately
    swap_point(1'b1);
    check("swp3_sel", 32'(fb_sel), 32'd1);
    check("swp3_ack", 32'(swap_ack), 32'd1);
    tick();
    check("swp3_ack_end", 32'(swap_ack), 32'd0);

    // Second buffer: last image address
    drive(1'b1, 10'd639, 10'd479, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check("buf1_addr", 32'(fb_addr), 32'd38399);
    check("buf1_rgb",  32'({vga_red, vga_green, vga_blue}), 32'h5FF);

    // Reset mid-frame drops the pending request
    drive(1'b0, 10'd0, 10'd100, 1'b1, 1'b1, 1'b0);
    pulse_req(10'd100);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_sel",  32'(fb_sel), 32'd0);
    check("mid_rst_addr", 32'(fb_addr), 32'd0);
    check("mid_rst_rgb",  32'({vga_red, vga_green, vga_blue}), 32'h000);
    swap_point(1'b0);
    check("mid_rst_lost_sel", 32'(fb_sel), 32'd0);
    check("mid_rst_lost_ack", 32'(swap_ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_display.md
Name: vga_fb_display

Overview:
Pixel-pipeline stage directly downstream of the VGA sync generator. It consumes visible/new_pxl/hsync/vsync/col/row and reads a double-buffered frame-buffer RAM of camera images. It upscales the image by 2**c_scale_log2, places it at the top-left of the screen, and drives registered RGB444 and sync pins to the VGA connector. It also arbitrates frame-buffer swaps requested by the camera writer, so swaps happen only during vertical blanking.

Parameters:
c_img_cols, 160, image width in pixels
c_img_rows, 120, image height in lines
c_scale_log2, 2, upscale factor exponent (image pixel = 2**c_scale_log2 square screen pixels)
c_nb_addr, 16, frame-buffer address width (must hold 2*c_img_cols*c_img_rows-1)
c_nb_pxl, 12, frame-buffer word width, RGB444 packed {R,G,B}
c_pxl_visible, 640, visible columns
c_line_visible, 480, visible lines
c_border, 12'h000, colour for visible pixels outside the image area
c_synch_act, 0, active level of hsync/vsync

Ports:
clk  in  1  system clock (100 MHz), single clock domain
rst  in  1  synchronous, active-low reset (rst=0 resets on rising clk)
visible  in  1  from sync generator: pixel in visible area
new_pxl  in  1  from sync generator: 1-clk pixel strobe (every 4 clks)
hsync_in  in  1  horizontal sync from sync generator
vsync_in  in  1  vertical sync from sync generator
col  in  10  current column
row  in  10  current line
test_mode  in  1  1 = colour bars instead of frame buffer
swap_req  in  1  1-clk pulse from camera writer: new frame complete
swap_ack  out  1  1-clk pulse: display buffer swapped
fb_sel  out  1  buffer currently displayed (writer uses ~fb_sel)
fb_addr  out  c_nb_addr  frame-buffer read address
fb_data  in  c_nb_pxl  frame-buffer read data, synchronous RAM, 1-clk latency
vga_red  out  4  red
vga_green  out  4  green
vga_blue  out  4  blue
vga_hsync  out  1  hsync to connector
vga_vsync  out  1  vsync to connector

Behaviour:
- Reset (rst=0 at rising clk): all pipeline registers cleared; fb_addr=0; RGB=0; vga_hsync=vga_vsync=~c_synch_act; fb_sel=0; swap_ack=0; pending=0.
- The pipeline advances every clk, not gated by new_pxl. Inputs are steady for 4 clks per pixel.
- Stage 1 (edge N):
  - in_img = col < c_img_cols<<c_scale_log2 AND row < c_img_rows<<c_scale_log2.
  - fb_addr <= fb_sel*c_img_cols*c_img_rows + (row>>c_scale_log2)*c_img_cols + (col>>c_scale_log2), truncated to c_nb_addr. The address is still computed when not in_img; the data is then ignored.
  - Register visible, in_img, hsync_in, vsync_in, col[8:6].
- Stage 2 (edge N+1): RAM returns fb_data. Flags and syncs are delayed one more register.
- Stage 3 (edge N+2), RGB select:
  - not visible: 0
  - test_mode: R={4{col[8]}}, G={4{col[7]}}, B={4{col[6]}}
  - not in_img: c_border
  - otherwise: fb_data split into R=[11:8], G=[7:4], B=[3:0]
- Latency: outputs and syncs both reflect inputs sampled 2 clks earlier, so sync/colour alignment is preserved exactly.
- Swap FSM, states IDLE and PENDING:
  - swap_req=1 sets PENDING; further requests while PENDING coalesce into one swap.
  - Swap point: new_pxl=1 AND row==c_line_visible AND col==0.
  - At the swap point while PENDING, or when swap_req arrives in that same clk: fb_sel toggles, swap_ack=1 for exactly 1 clk, state goes to IDLE.
  - fb_sel never changes outside the swap point, so there is no tearing.
- Reset mid-frame: fb_sel returns to 0 and any pending request is lost; the writer must re-request.
- Wrap-around: the last image address with fb_sel=1 is 2*c_img_cols*c_img_rows-1 (38399 at defaults). No overflow for legal parameters.

Decomposition:
- Package vga_pkg: VGA timing constants (visible/porch/sync counts), colour widths, image dimensions, c_synch_act, RGB444 field slices.
- Natural sub-module: vga_fb_addr_gen (stage-1 scaled address and in_img computation, including the fb_sel base offset).
- Swap FSM and output pipeline stay in the top.

Test Plan:
- Reset: hold rst=0 for 3 clks -> RGB=0, vga_hsync=vga_vsync=1, fb_sel=0, swap_ack=0, fb_addr=0.
- Addressing: fb_sel=0; col=4,row=0 -> fb_addr=1. col=639,row=479 -> fb_addr=19199. After a swap to fb_sel=1, same pixel -> 38399.
- Latency: RAM model returns 12'hA5C for a visible in-image pixel -> RGB=A,5,C exactly 2 clks after inputs applied. hsync_in falling edge appears on vga_hsync exactly 2 clks later.
- Border/blank: c_scale_log2=1, col=320,row=10,visible=1 -> RGB=c_border. visible=0 -> RGB=0 regardless of fb_data.
- Test mode: test_mode=1, col=448 (bits 8:6=111) -> R=G=B=4'hF. col=64 -> R=0,G=0,B=F.
- Swap: swap_req pulse at row=100 -> fb_sel unchanged until new_pxl at row=480,col=0, then toggles with a 1-clk swap_ack. Two reqs in one frame -> a single toggle. Req in the swap-point clk -> immediate toggle and ack.
